// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: PC-select codes, ctrl_word field
// positions and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REG  = 2'b10;
    localparam logic [1:0] PS_BR   = 2'b11;

    // Location of the PC-select field inside control_unit's ctrl_word.
    localparam int unsigned PS_MSB = 7;
    localparam int unsigned PS_LSB = 6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StIssue = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: hold, +4, register target (word-masked) or PC-relative
// branch with a word-scaled immediate. Purely combinational.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        ps,
    input  logic [ADDR_W-1:0] k,
    input  logic [ADDR_W-1:0] r_in,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_br;
    logic [ADDR_W-1:0] pc_reg;

    // Shifting k left drops its top two bits; sums wrap modulo 2^ADDR_W.
    assign pc_inc = pc + ADDR_W'(4);
    assign pc_br  = pc + (k << 2);
    assign pc_reg = r_in & ~ADDR_W'(3);

    always_comb begin
        next_pc = pc;
        unique case (ps)
            PS_HOLD: next_pc = pc;
            PS_INC:  next_pc = pc_inc;
            PS_REG:  next_pc = pc_reg;
            PS_BR:   next_pc = pc_br;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds the instruction for control_unit until it selects the next PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ps,
    input  logic [ADDR_W-1:0] k,
    input  logic [ADDR_W-1:0] r_in,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [31:0]       i,
    output logic              i_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       i_q;
    logic [ADDR_W-1:0] next_pc;

    fetch_unit_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc      (pc_q),
        .ps      (ps),
        .k       (k),
        .r_in    (r_in),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            pc_q  <= PC_RESET;
            i_q   <= '0;
        end else begin
            case (state)
                StIdle: state <= StReq;
                StReq: begin
                    if (imem_ack) begin
                        i_q   <= imem_data;
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    // Stall wins over ps; PS_HOLD keeps a multi-cycle instruction in place.
                    if (!stall && ps != PS_HOLD) begin
                        pc_q  <= next_pc;
                        state <= StReq;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Handshake flags come straight from the state register so reset drops them at once.
    assign imem_req  = (state == StReq);
    assign i_valid   = (state == StIssue);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign i         = i_q;
    assign pc4       = pc_q + ADDR_W'(4);

endmodule
